// File: rtl/btn_gesture.sv
// Button gesture classifier: short, double and long press
// from the debounced level and press tick.
module btn_gesture #(
  parameter int CNT_W    = 26,
  parameter int LONG_CYC = 50_000_000,
  parameter int DBL_CYC  = 15_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic db_level,
  input  logic db_tick,
  output logic short_tick,
  output logic double_tick,
  output logic long_tick,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP,
    WAIT_REL
  } state_t;

  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_T  = CNT_W'(DBL_CYC - 1);

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic               lvl_d;
  logic               short_n;
  logic               double_n;
  logic               long_n;
  logic               press;
  logic               rel;

  assign press = db_tick;
  assign rel   = lvl_d & ~db_level;
  assign busy  = (state != IDLE);

  // State, counter, level history and registered tick outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lvl_d       <= 1'b0;
      short_tick  <= 1'b0;
      double_tick <= 1'b0;
      long_tick   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      lvl_d       <= db_level;
      short_tick  <= short_n;
      double_tick <= double_n;
      long_tick   <= long_n;
    end
  end

  // Gesture classification; release/press win over terminal count.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    short_n  = 1'b0;
    double_n = 1'b0;
    long_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (press) begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (rel) begin
          state_n = GAP;
          cnt_n   = '0;
        end else if (cnt == LONG_T) begin
          long_n  = 1'b1;
          state_n = WAIT_REL;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (press) begin
          double_n = 1'b1;
          state_n  = WAIT_REL;
        end else if (cnt == DBL_T) begin
          short_n = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (rel) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_gesture.sv
// Randomized scoreboard bench for btn_gesture.
// Expected gestures come from press/release timing arithmetic.
module tb_btn_gesture;

  localparam int CW = 8;
  localparam int L  = 20;
  localparam int D  = 10;
  localparam int NB = 32768;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic db_level;
  logic db_tick;
  logic short_tick;
  logic double_tick;
  logic long_tick;
  logic busy;

  ev_t  sbq[$];
  bit   busy_exp[NB];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur = 0;
  int   base = 0;
  bit   mon_en = 1'b0;

  int   pp[$];
  int   rr[$];
  int   sp[$];
  int   rst_at;

  btn_gesture #(
    .CNT_W   (CW),
    .LONG_CYC(L),
    .DBL_CYC (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .db_level   (db_level),
    .db_tick    (db_tick),
    .short_tick (short_tick),
    .double_tick(double_tick),
    .long_tick  (long_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic string kname(int k);
    if (k == 0) return "short";
    if (k == 1) return "double";
    if (k == 2) return "long";
    return "none";
  endfunction

  function automatic void add_ev(int c, int k);
    ev_t e;
    if (rst_at < 0 || c <= rst_at) begin
      e.cyc  = base + c;
      e.kind = k;
      sbq.push_back(e);
    end
  endfunction

  function automatic void mark_busy(int a, int b);
    for (int c = a; c <= b; c++)
      if (rst_at < 0 || c <= rst_at)
        busy_exp[(base + c) % NB] = 1'b1;
  endfunction

  // Gesture outcome from press/release times of successive pulses.
  function automatic void model();
    int i = 0;
    while (i < pp.size()) begin
      int p = pp[i];
      int r = rr[i];
      if (r - p > L) begin
        add_ev(p + L + 1, 2);
        mark_busy(p + 1, r);
        i += 1;
      end else if (i + 1 < pp.size() && pp[i+1] <= r + D) begin
        add_ev(pp[i+1] + 1, 1);
        mark_busy(p + 1, rr[i+1]);
        i += 2;
      end else begin
        add_ev(r + D + 1, 0);
        mark_busy(p + 1, r + D);
        i += 1;
      end
    end
  endfunction

  task automatic run_stream();
    int slen;
    slen = rr[rr.size()-1] + D + 6;
    for (int c = 0; c < slen; c++)
      busy_exp[(base + c) % NB] = 1'b0;
    model();
    mon_en = 1'b1;
    for (int c = 0; c < slen; c++) begin
      bit lv;
      bit tk;
      lv = 1'b0;
      tk = 1'b0;
      foreach (pp[k]) begin
        if (c >= pp[k] && c < rr[k]) lv = 1'b1;
        if (c == pp[k]) tk = 1'b1;
      end
      foreach (sp[k])
        if (c == sp[k]) tk = 1'b1;
      @(posedge clk);
      #1;
      cur      = base + c;
      reset    = (c == rst_at);
      db_level = lv;
      db_tick  = tk;
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_empty: %0d pending, required 0 (next %s @%0d)",
               sbq.size(), kname(sbq[0].kind), sbq[0].cyc);
      sbq.delete();
    end
    base += slen;
  endtask

  task automatic clr();
    pp.delete();
    rr.delete();
    sp.delete();
    rst_at = -1;
  endtask

  task automatic pulse(int p, int r);
    pp.push_back(p);
    rr.push_back(r);
  endtask

  // Monitor: busy every cycle, ticks popped from scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      int k;
      int nt;
      n_cmp++;
      if (busy !== busy_exp[cur % NB]) begin
        n_bad++;
        $display("FAIL busy @%0d: got %b, required %b",
                 cur, busy, busy_exp[cur % NB]);
      end
      nt = int'(short_tick) + int'(double_tick) + int'(long_tick);
      n_cmp++;
      if (nt > 1) begin
        n_bad++;
        $display("FAIL onehot @%0d: got %0d ticks, required <=1", cur, nt);
      end
      while (sbq.size() != 0 && sbq[0].cyc < cur) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed %s: got none at %0d, required tick",
                 kname(sbq[0].kind), sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (nt > 0) begin
        k = short_tick ? 0 : (double_tick ? 1 : 2);
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL tick @%0d: got %s, required none", cur, kname(k));
        end else if (sbq[0].cyc != cur || sbq[0].kind != k) begin
          n_bad++;
          $display("FAIL tick @%0d: got %s, required %s @%0d",
                   cur, kname(k), kname(sbq[0].kind), sbq[0].cyc);
          if (sbq[0].cyc == cur) void'(sbq.pop_front());
        end else begin
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    db_level = 1'b0;
    db_tick  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // short press
    clr(); pulse(2, 7); run_stream();
    // long press
    clr(); pulse(2, 42); run_stream();
    // double press, 2nd press 4 cycles into gap
    clr(); pulse(2, 6); pulse(10, 13); run_stream();
    // release on long terminal count
    clr(); pulse(2, 2 + L); run_stream();
    // 2nd press on gap terminal count
    clr(); pulse(2, 6); pulse(6 + D, 19); run_stream();
    // reset mid-hold, then fresh short press
    clr(); pulse(2, 13); rst_at = 13; run_stream();
    clr(); pulse(2, 6); run_stream();
    // reset mid-gap, then fresh short press
    clr(); pulse(2, 6); rst_at = 12; run_stream();
    clr(); pulse(2, 6); run_stream();
    // spurious ticks in hold and wait-release
    clr(); pulse(2, 7); sp.push_back(4); run_stream();
    clr(); pulse(2, 42); sp.push_back(10); sp.push_back(30); run_stream();

    // random gesture streams
    for (int s = 0; s < 40; s++) begin
      int t;
      int n;
      clr();
      t = 2 + int'($urandom_range(0, 2));
      n = 1 + int'($urandom_range(0, 5));
      for (int k = 0; k < n; k++) begin
        int h;
        int g;
        case ($urandom_range(0, 3))
          0: h = int'($urandom_range(1, L));
          1: h = int'($urandom_range(L + 1, L + 15));
          2: h = L + int'($urandom_range(0, 1));
          default: h = int'($urandom_range(1, 5));
        endcase
        pulse(t, t + h);
        if (h >= 3 && $urandom_range(0, 2) == 0)
          sp.push_back(t + 1 + int'($urandom_range(0, h - 2)));
        if ($urandom_range(0, 2) == 0)
          g = D + int'($urandom_range(0, 1));
        else
          g = int'($urandom_range(1, D + 4));
        t = t + h + g;
      end
      run_stream();
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
